// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display blocks.
// Contents: default widths, all-dark segment code and the active-low hex glyph table.
package seg_pkg;

  localparam int unsigned DIGITS_DEF = 8;
  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned SEG_W      = 7;

  // All segments dark (active-low).
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs, entry n at index n (entry 0 is the LSB slice).
  localparam logic [15:0][SEG_W-1:0] HEX7 = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
    7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex-to-7-segment decoder (active-low gfedcba).
// Ports:
//   i_data   in   DATA_W  nibble to display
//   o_seg_c  out  7       active-low segment pattern (combinational)
module hex7seg_dec
  import seg_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [SEG_W-1:0]  o_seg_c
);

  // Table lookup; the index is normalised to the 16-entry table width.
  always_comb begin
    o_seg_c = HEX7[4'(i_data)];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver.
// Walks the register-file read address across all digits, latches the returned nibble
// one cycle into each slot, and lights one digit at a time with a blanking gap at the
// end of every slot to avoid ghosting.
// Ports:
//   i_clk         in   1       system clock, rising edge
//   i_rst         in   1       synchronous reset, active-high
//   i_scan_en     in   1       1 = scan runs; 0 = counters frozen, display dark
//   i_rd_data     in   DATA_W  nibble returned by the register file (combinational read)
//   o_rd_addr     out  ADDR_W  register-file read address (current digit index)
//   o_an_n        out  DIGITS  digit enables, active-low, at most one low
//   o_seg_n       out  7       segments {g,f,e,d,c,b,a}, active-low
//   o_frame_done  out  1       pulse in the final cycle of the last digit slot
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS  = DIGITS_DEF,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned BLANK   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_scan_en,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DIGITS-1:0] o_an_n,
  output logic [SEG_W-1:0]  o_seg_n,
  output logic              o_frame_done
);

  localparam int unsigned P_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [P_W-1:0]    P_LAST   = P_W'(CLK_DIV - 1);
  localparam logic [P_W-1:0]    P_LATCH  = P_W'(1);
  localparam logic [P_W-1:0]    P_ON     = P_W'(2);
  localparam logic [P_W-1:0]    P_OFF    = P_W'(CLK_DIV - 1 - BLANK);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DIGITS - 1);

  logic [P_W-1:0]    r_p;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_data_q;
  logic [DIGITS-1:0] r_an_n;
  logic [SEG_W-1:0]  r_seg_n;

  logic [P_W-1:0]    w_p_nx;
  logic [ADDR_W-1:0] w_idx_nx;
  logic [DATA_W-1:0] w_data_nx;
  logic [DIGITS-1:0] w_an_nx;
  logic [SEG_W-1:0]  w_seg_nx;
  logic [SEG_W-1:0]  w_seg_dec;
  logic              w_p_last;
  logic              w_idx_last;

  assign w_p_last   = (r_p == P_LAST);
  assign w_idx_last = (r_idx == IDX_LAST);

  // Glyph for the value that will be held in the latch after this edge.
  hex7seg_dec #(
    .DATA_W (DATA_W)
  ) u_dec (
    .i_data  (w_data_nx),
    .o_seg_c (w_seg_dec)
  );

  // Next-state: phase/digit counters, nibble latch, and the registered drive pattern.
  // The drive pattern is computed from the next phase so the lit window lines up
  // with the phase the counter shows during that cycle.
  always_comb begin
    w_p_nx    = r_p;
    w_idx_nx  = r_idx;
    w_data_nx = r_data_q;
    w_an_nx   = '1;
    w_seg_nx  = SEG_OFF;

    if (i_scan_en) begin
      if (w_p_last) begin
        w_p_nx   = '0;
        w_idx_nx = w_idx_last ? '0 : r_idx + ADDR_W'(1);
      end else begin
        w_p_nx = r_p + P_W'(1);
      end

      // Address has been stable since the slot boundary, so the read is settled here.
      if (r_p == P_LATCH) begin
        w_data_nx = i_rd_data;
      end

      if ((w_p_nx >= P_ON) && (w_p_nx <= P_OFF)) begin
        w_an_nx  = ~(DIGITS'(1) << w_idx_nx);
        w_seg_nx = w_seg_dec;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p      <= '0;
      r_idx    <= '0;
      r_data_q <= '0;
      r_an_n   <= '1;
      r_seg_n  <= SEG_OFF;
    end else begin
      r_p      <= w_p_nx;
      r_idx    <= w_idx_nx;
      r_data_q <= w_data_nx;
      r_an_n   <= w_an_nx;
      r_seg_n  <= w_seg_nx;
    end
  end

  assign o_rd_addr = r_idx;
  assign o_an_n    = r_an_n;
  assign o_seg_n   = r_seg_n;

  // Qualified by the live enable so a frozen final slot never reports completion.
  assign o_frame_done = i_scan_en & ~i_rst & w_p_last & w_idx_last;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int unsigned DIGITS  = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned CLK_DIV = 8;
  localparam int unsigned BLANK   = 2;
  localparam int unsigned FRAME   = DIGITS * CLK_DIV;

  logic              clk = 1'b0;
  logic              rst;
  logic              scan_en;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DIGITS-1:0] an_n;
  logic [6:0]        seg_n;
  logic              frame_done;

  logic [DATA_W-1:0] regs [DIGITS];

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: position t counts enabled cycles since reset.
  int t;
  int dq;
  bit last_en;

  int n_cmp;
  int n_bad;
  int n_fd;

  always #5 clk = ~clk;

  always_comb rd_data = regs[rd_addr];

  seg_scan_driver #(
    .DIGITS  (DIGITS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .BLANK   (BLANK)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_scan_en    (scan_en),
    .i_rd_data    (rd_data),
    .o_rd_addr    (rd_addr),
    .o_an_n       (an_n),
    .o_seg_n      (seg_n),
    .o_frame_done (frame_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
    end
  endtask

  // One clock: apply inputs at the falling edge, check, then advance the model.
  task automatic cyc(input bit r, input bit e, input bit w, input int wa,
                     input logic [DATA_W-1:0] wv);
    int p;
    int idx;
    bit lit;
    logic [DIGITS-1:0] an_e;
    logic [6:0] seg_e;
    bit fd_e;
    @(negedge clk);
    rst     = r;
    scan_en = e;
    if (w) regs[wa] = wv;
    #1;
    p    = t % CLK_DIV;
    idx  = (t / CLK_DIV) % DIGITS;
    lit  = last_en && (p >= 2) && (p <= int'(CLK_DIV - 1 - BLANK));
    an_e  = lit ? ~(DIGITS'(1) << idx) : '1;
    seg_e = lit ? hex_tab[dq] : 7'h7F;
    fd_e  = !r && e && (idx == DIGITS - 1) && (p == CLK_DIV - 1);
    check_eq("rd_addr", 32'(rd_addr), 32'(idx));
    check_eq("an_n", 32'(an_n), 32'(an_e));
    check_eq("seg_n", 32'(seg_n), 32'(seg_e));
    check_eq("frame_done", 32'(frame_done), 32'(fd_e));
    if (frame_done) n_fd++;
    @(posedge clk);
    if (r) begin
      t = 0; dq = 0; last_en = 0;
    end else if (e) begin
      if (p == 1) dq = int'(regs[idx]);
      t = (t + 1) % FRAME;
      last_en = 1;
    end else begin
      last_en = 0;
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_fd = 0;
    for (int k = 0; k < int'(DIGITS); k++) regs[k] = DATA_W'(k + 1);
    rst = 1'b1; scan_en = 1'b1;
    repeat (2) @(posedge clk);
    t = 0; dq = 0; last_en = 0;

    // Reset held with scan enabled.
    repeat (3) cyc(1, 1, 0, 0, '0);

    // One full frame: exactly one completion pulse.
    n_fd = 0;
    repeat (FRAME) cyc(0, 1, 0, 0, '0);
    check_eq("fd_count", 32'(n_fd), 32'd1);
    cyc(0, 1, 0, 0, '0);

    // Pause at digit 3, phase 4, for 10 cycles, then resume.
    for (int i = 0; i < int'(FRAME) && t != 3 * CLK_DIV + 4; i++) cyc(0, 1, 0, 0, '0);
    repeat (10) cyc(0, 0, 0, 0, '0);
    repeat (12) cyc(0, 1, 0, 0, '0);

    // Rewrite slot 2 while digit 2 is lit.
    for (int i = 0; i < int'(FRAME) && t != 2 * CLK_DIV + 3; i++) cyc(0, 1, 0, 0, '0);
    cyc(0, 1, 1, 2, 4'hA);
    repeat (FRAME + 8) cyc(0, 1, 0, 0, '0);

    // Reset mid-frame at digit 5, phase 3.
    for (int i = 0; i < int'(FRAME) && t != 5 * CLK_DIV + 3; i++) cyc(0, 1, 0, 0, '0);
    n_fd = 0;
    cyc(1, 1, 0, 0, '0);
    repeat (8) cyc(0, 1, 0, 0, '0);
    check_eq("fd_after_rst", 32'(n_fd), 32'd0);

    // Drop enable exactly on the wrap cycle of the last slot.
    for (int i = 0; i < int'(FRAME) && t != FRAME - 1; i++) cyc(0, 1, 0, 0, '0);
    repeat (3) cyc(0, 0, 0, 0, '0);
    repeat (4) cyc(0, 1, 0, 0, '0);

    // Random enable gaps, register writes and occasional resets.
    repeat (3000) begin
      cyc(($urandom % 200) == 0, ($urandom % 8) != 0, ($urandom % 4) == 0,
          int'($urandom % DIGITS), DATA_W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
